fetch_decode_reg: RTL and testbench

Parametrised IF/ID pipeline register for the exception-capable five-stage MIPS core. It holds the fetched instruction, its PC, a valid bit and the fetch exception code. It supports stall (hold) and flush (bubble with programmable PC). It derives the branch-delay-slot flag internally, decodes the branch/jump class of the held instruction, and keeps saturating stall/flush performance counters.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/br_class.sv | 46 ++++
 rtl/fetch_decode_reg.sv | 120 ++++++++++++
 tb/tb_fetch_decode_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core.
// Holds opcode/funct/rt field values for control-transfer instructions,
// the pc_src branch-class encodings, exception codes and the reset PC.
package cpu_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  // Funct field values (instr[5:0]) under OP_SPECIAL
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  // rt field values (instr[20:16]) under OP_REGIMM
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // Branch-class encodings driven on pc_src
  localparam int unsigned PC_SRC_W = 4;
  localparam logic [PC_SRC_W-1:0] PC_SRC_NONE = 4'd0;
  localparam logic [PC_SRC_W-1:0] PC_SRC_BEQ  = 4'd1;
  localparam logic [PC_SRC_W-1:0] PC_SRC_J    = 4'd2;
  localparam logic [PC_SRC_W-1:0] PC_SRC_JR   = 4'd3;
  localparam logic [PC_SRC_W-1:0] PC_SRC_BNE  = 4'd4;
  localparam logic [PC_SRC_W-1:0] PC_SRC_BLEZ = 4'd5;
  localparam logic [PC_SRC_W-1:0] PC_SRC_BGTZ = 4'd6;
  localparam logic [PC_SRC_W-1:0] PC_SRC_BLTZ = 4'd7;
  localparam logic [PC_SRC_W-1:0] PC_SRC_BGEZ = 4'd8;

  // Exception codes
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // PC after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/br_class.sv
// Combinational branch/jump class decoder.
// Ports:
//   instr  in  INSTR_W  instruction word (opcode [31:26], rt [20:16], funct [5:0])
//   pc_src out PC_SRC_W class code, PC_SRC_NONE for anything that is not a
//                       control transfer (including unknown REGIMM rt values)
// Stateless, so the ID-stage comparator can reuse it directly.
module br_class
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = 32
) (
  input  logic [INSTR_W-1:0]  instr,
  output logic [PC_SRC_W-1:0] pc_src
);

  logic [5:0] opcode;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instr[31:26];
  assign rt     = instr[20:16];
  assign funct  = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  always_comb begin
    pc_src = PC_SRC_NONE;
    unique case (opcode)
      OP_BEQ:  pc_src = PC_SRC_BEQ;
      OP_J,
      OP_JAL:  pc_src = PC_SRC_J;
      OP_BNE:  pc_src = PC_SRC_BNE;
      OP_BLEZ: pc_src = PC_SRC_BLEZ;
      OP_BGTZ: pc_src = PC_SRC_BGTZ;
      OP_SPECIAL: begin
        if (funct == FUNCT_JR || funct == FUNCT_JALR) pc_src = PC_SRC_JR;
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ)      pc_src = PC_SRC_BLTZ;
        else if (rt == RT_BGEZ) pc_src = PC_SRC_BGEZ;
      end
      default: pc_src = PC_SRC_NONE;
    endcase
  end

endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register with stall, flush, delay-slot tracking and
// saturating stall/flush performance counters.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   stall             hold every register this cycle
//   flush             load a bubble at flush_pc (wins over stall)
//   flush_pc          PC given to the bubble on flush
//   in_valid/instr/pc/exc   fetch-stage slot
//   instr/pc/valid/exc      held slot (one cycle after in_*)
//   bd                held instruction is in a branch delay slot
//   pc_src            branch class of the held instruction (0 when invalid)
//   stall_cnt         cycles stalled while holding a valid instruction
//   flush_cnt         number of flush events
// Slot semantics: there is no back-pressure handshake. valid qualifies the
// held slot; a slot with valid=0 is a bubble and carries instr=0, exc=0.
// stall is the only hold mechanism and applies to the whole register.
module fetch_decode_reg
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSTR_W  = 32,
  parameter int unsigned     EXC_W    = 5,
  parameter int unsigned     CNT_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic [PC_W-1:0]     flush_pc,
  input  logic                in_valid,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [EXC_W-1:0]    in_exc,
  output logic [INSTR_W-1:0]  instr,
  output logic [PC_W-1:0]     pc,
  output logic                valid,
  output logic [EXC_W-1:0]    exc,
  output logic                bd,
  output logic [PC_SRC_W-1:0] pc_src,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [EXC_W-1:0]    exc_q, exc_d;
  logic                bd_q, bd_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [PC_SRC_W-1:0] held_class;

  br_class #(.INSTR_W(INSTR_W)) u_br_class (
    .instr  (instr_q),
    .pc_src (held_class)
  );

  // A stale instruction left in a bubble must never look like a branch.
  assign pc_src = valid_q ? held_class : PC_SRC_NONE;

  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    exc_d       = exc_q;
    bd_d        = bd_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (flush) begin
      instr_d = '0;
      pc_d    = flush_pc;
      valid_d = 1'b0;
      exc_d   = '0;
      bd_d    = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (stall) begin
      if (valid_q && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      valid_d = in_valid;
      pc_d    = in_pc;
      // A faulting fetch becomes a nop that still carries its exception.
      exc_d   = in_valid ? in_exc : '0;
      instr_d = (in_valid && in_exc == '0) ? in_instr : '0;
      // The incoming slot follows the currently held instruction, so it is
      // a delay slot exactly when the held one is a valid control transfer.
      bd_d    = in_valid && (pc_src != PC_SRC_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q     <= '0;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      exc_q       <= '0;
      bd_q        <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      exc_q       <= exc_d;
      bd_q        <= bd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign instr     = instr_q;
  assign pc        = pc_q;
  assign valid     = valid_q;
  assign exc       = exc_q;
  assign bd        = bd_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Testbench for fetch_decode_reg: directed sequence followed by randomized
// traffic, with a reference model pushing expected outputs into a queue and
// a negedge monitor popping and comparing them.
module tb_fetch_decode_reg;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_exc = '0;

  logic [31:0]      instr;
  logic [31:0]      pc;
  logic             valid;
  logic [4:0]       exc;
  logic             bd;
  logic [3:0]       pc_src;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  fetch_decode_reg #(
    .PC_W(32), .INSTR_W(32), .EXC_W(5), .CNT_W(CNT_W), .RESET_PC(32'h0000_3000)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
    .instr(instr), .pc(pc), .valid(valid), .exc(exc), .bd(bd), .pc_src(pc_src),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [4:0]  exc;
    logic        bd;
    logic [3:0]  pc_src;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("instr",     instr,             e.instr);
      chk("pc",        pc,                e.pc);
      chk("valid",     {31'd0, valid},    {31'd0, e.valid});
      chk("exc",       {27'd0, exc},      {27'd0, e.exc});
      chk("bd",        {31'd0, bd},       {31'd0, e.bd});
      chk("pc_src",    {28'd0, pc_src},   {28'd0, e.pc_src});
      chk("stall_cnt", 32'(stall_cnt),    e.stall_cnt);
      chk("flush_cnt", 32'(flush_cnt),    e.flush_cnt);
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc    = '0;
  logic        m_valid = 1'b0;
  logic [4:0]  m_exc   = '0;
  logic        m_bd    = 1'b0;
  int          m_scnt  = 0;
  int          m_fcnt  = 0;

  // Branch class straight from the instruction-set table.
  function automatic int ref_class(input logic [31:0] w);
    int op, rt, fn;
    op = int'(w[31:26]);
    rt = int'(w[20:16]);
    fn = int'(w[5:0]);
    if (op == 4) return 1;
    if (op == 2 || op == 3) return 2;
    if (op == 0 && (fn == 8 || fn == 9)) return 3;
    if (op == 5) return 4;
    if (op == 6) return 5;
    if (op == 7) return 6;
    if (op == 1 && rt == 0) return 7;
    if (op == 1 && rt == 1) return 8;
    return 0;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                       input logic iv, input logic [31:0] ii, input logic [31:0] ipc,
                       input logic [4:0] iexc);
    exp_t e;
    int   cls_held;
    @(negedge clk);
    reset = r; stall = s; flush = f; flush_pc = fpc;
    in_valid = iv; in_instr = ii; in_pc = ipc; in_exc = iexc;
    @(posedge clk);
    cls_held = m_valid ? ref_class(m_instr) : 0;
    if (r) begin
      m_instr = 0; m_pc = 32'h0000_3000; m_valid = 0; m_exc = 0; m_bd = 0;
      m_scnt = 0; m_fcnt = 0;
    end else if (f) begin
      m_instr = 0; m_pc = fpc; m_valid = 0; m_exc = 0; m_bd = 0;
      if (m_fcnt < CNT_MAX) m_fcnt++;
    end else if (s) begin
      if (m_valid && m_scnt < CNT_MAX) m_scnt++;
    end else begin
      m_bd    = iv && (cls_held != 0);
      m_valid = iv;
      m_pc    = ipc;
      m_exc   = iv ? iexc : 5'd0;
      m_instr = (iv && iexc == 0) ? ii : 32'd0;
    end
    e.instr     = m_instr;
    e.pc        = m_pc;
    e.valid     = m_valid;
    e.exc       = m_exc;
    e.bd        = m_bd;
    e.pc_src    = 4'(m_valid ? ref_class(m_instr) : 0);
    e.stall_cnt = 32'(m_scnt);
    e.flush_cnt = 32'(m_fcnt);
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [31:0] ii, input logic [31:0] ipc, input logic [4:0] iexc);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, ii, ipc, iexc);
  endtask

  task automatic stall_rand;
    cycle(1'b0, 1'b1, 1'b0, $urandom, 1'(($urandom)), $urandom, $urandom, 5'($urandom));
  endtask

  function automatic logic [31:0] rand_instr;
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 2) != 0) w[31:26] = 6'($urandom_range(0, 7));
    if ($urandom_range(0, 1) != 0) w[20:16] = 5'($urandom_range(0, 2));
    if ($urandom_range(0, 1) != 0) w[5:0]   = 6'($urandom_range(7, 10));
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for two cycles
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0);

    // beq then addu in its delay slot, then jr
    load(32'h1085_0003, 32'h0000_3000, 5'd0);
    load(32'h0085_1021, 32'h0000_3004, 5'd0);
    load(32'h03E0_0008, 32'h0000_3008, 5'd0);

    // Held jr under stall with changing inputs
    repeat (3) stall_rand();

    // Flush beats stall
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_4180, 1'b1, 32'h1234_5678, 32'h0000_5000, 5'd0);

    // Faulting fetch becomes a nop carrying its exception
    load(32'hFFFF_FFFF, 32'h0000_3001, 5'd4);

    // Stall with valid held long enough to saturate the counter
    repeat (5) stall_rand();

    // REGIMM decode: bgez, then an rt value with no class
    load(32'h0421_0004, 32'h0000_3100, 5'd0);
    load(32'h0610_0004, 32'h0000_3104, 5'd0);
    // Bubble behind a branch gets no delay-slot flag
    load(32'h1000_0001, 32'h0000_3108, 5'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF, 32'h0000_310C, 5'd0);

    // Repeated flushes saturate the flush counter
    repeat (4) cycle(1'b0, 1'b0, 1'b1, $urandom, 1'b1, $urandom, $urandom, 5'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] e;
      e = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      cycle(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 7) == 0), $urandom,
            1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, e);
    end

    // Drain the scoreboard
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
